// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is split into STAGES registered segments.
// Define PIPE_ADDSUB_OVF_EN to add the registered signed-overflow output ovf.
module pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef PIPE_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int SEG = WIDTH / STAGES;

    logic [WIDTH-1:0]  b_eff;
    logic              c_eff;
    logic [STAGES-1:0] carry_reg;
    logic [STAGES-1:0] valid_reg;
`ifdef PIPE_ADDSUB_OVF_EN
    logic              top_a_msb;
    logic              top_b_msb;
    logic              top_s_msb;
    logic              ovf_reg;
`endif

    // Subtraction is folded in at the input: a + ~b + ~cin, so downstream stages only add.
    assign b_eff = sub ? ~b : b;
    assign c_eff = cin ^ sub;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
        end else if (ce) begin
            valid_reg[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                valid_reg[k] <= valid_reg[k-1];
            end
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_seg
        localparam int LO    = gi * SEG;
        localparam int DEPTH = STAGES - gi;

        logic [SEG-1:0] a_op;
        logic [SEG-1:0] b_op;
        logic           c_op;
        logic [SEG:0]   seg_sum;
        logic [SEG-1:0] res_reg [0:DEPTH-1];

        if (gi == 0) begin : g_direct
            assign a_op = a[SEG-1:0];
            assign b_op = b_eff[SEG-1:0];
            assign c_op = c_eff;
        end else begin : g_skew
            // Operands wait gi cycles so they meet the carry produced by segment gi-1.
            logic [SEG-1:0] a_dly_reg [1:gi];
            logic [SEG-1:0] b_dly_reg [1:gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 1; k <= gi; k++) begin
                        a_dly_reg[k] <= '0;
                        b_dly_reg[k] <= '0;
                    end
                end else if (ce) begin
                    a_dly_reg[1] <= a[LO +: SEG];
                    b_dly_reg[1] <= b_eff[LO +: SEG];
                    for (int k = 2; k <= gi; k++) begin
                        a_dly_reg[k] <= a_dly_reg[k-1];
                        b_dly_reg[k] <= b_dly_reg[k-1];
                    end
                end
            end

            assign a_op = a_dly_reg[gi];
            assign b_op = b_dly_reg[gi];
            assign c_op = carry_reg[gi-1];
        end

        assign seg_sum = {1'b0, a_op} + {1'b0, b_op} + {{SEG{1'b0}}, c_op};

        always_ff @(posedge clk) begin
            if (rst) begin
                carry_reg[gi] <= 1'b0;
                for (int k = 0; k < DEPTH; k++) begin
                    res_reg[k] <= '0;
                end
            end else if (ce) begin
                carry_reg[gi] <= seg_sum[SEG];
                res_reg[0]    <= seg_sum[SEG-1:0];
                for (int k = 1; k < DEPTH; k++) begin
                    res_reg[k] <= res_reg[k-1];
                end
            end
        end

        // Lower segments finish early and are delayed here so all of s lines up.
        assign s[LO +: SEG] = res_reg[DEPTH-1];

`ifdef PIPE_ADDSUB_OVF_EN
        if (gi == STAGES - 1) begin : g_top
            assign top_a_msb = a_op[SEG-1];
            assign top_b_msb = b_op[SEG-1];
            assign top_s_msb = seg_sum[SEG-1];
        end
`endif
    end

`ifdef PIPE_ADDSUB_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (ce) begin
            ovf_reg <= (top_a_msb == top_b_msb) && (top_s_msb != top_a_msb);
        end
    end

    assign ovf = ovf_reg;
`endif

    assign cout      = carry_reg[STAGES-1];
    assign out_valid = valid_reg[STAGES-1];

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: a 4-bit/2-stage and a 32-bit/4-stage instance (plus an
// 8-bit/2-stage instance checking ovf when PIPE_ADDSUB_OVF_EN is defined) share one stimulus stream.
module tb_pipe_addsub;
    logic        clk = 1'b0;
    logic        rst, ce, in_valid, cin, sub;
    logic [31:0] a, b;
    logic        ov4, c4, ov32, c32;
    logic [3:0]  s4;
    logic [31:0] s32;
    logic [35:0] act4, act32;
`ifdef PIPE_ADDSUB_OVF_EN
    logic        f4, f32, ov8, c8, f8;
    logic [7:0]  s8;
    logic [35:0] act8, prev8;
`endif

    always #5 clk = ~clk;

    pipe_addsub #(.WIDTH(4), .STAGES(2)) u4 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a[3:0]), .b(b[3:0]),
        .cin(cin), .sub(sub), .out_valid(ov4), .s(s4), .cout(c4)
`ifdef PIPE_ADDSUB_OVF_EN
        , .ovf(f4)
`endif
    );

    pipe_addsub #(.WIDTH(32), .STAGES(4)) u32 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov32), .s(s32), .cout(c32)
`ifdef PIPE_ADDSUB_OVF_EN
        , .ovf(f32)
`endif
    );

`ifdef PIPE_ADDSUB_OVF_EN
    pipe_addsub #(.WIDTH(8), .STAGES(2)) u8 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a[7:0]), .b(b[7:0]),
        .cin(cin), .sub(sub), .out_valid(ov8), .s(s8), .cout(c8), .ovf(f8)
    );
    assign act8 = {25'b0, ov8, f8, c8, s8};
`endif

    assign act4  = {30'b0, ov4, c4, s4};
    assign act32 = {2'b0, ov32, c32, s32};

    typedef struct { logic [32:0] e4; logic [32:0] e8; int due; } exp2_t;
    typedef struct { logic [32:0] e32; int due; } exp4_t;
    typedef struct {
        logic        sb;
        logic [31:0] x;
        logic [31:0] y;
        logic        c;
        logic [32:0] res;
        logic        ovf;
    } vec_t;

    exp2_t       q2[$];
    exp4_t       q4[$];
    vec_t        tab[11];
    int          tests = 0;
    int          fails = 0;
    int          ecnt  = 0;
    logic        use_tab;
    logic [32:0] tab_res;
    logic        tab_ovf;
    logic [35:0] prev4, prev32;

    function automatic logic [32:0] model4(input logic sb, input logic [3:0] x,
                                           input logic [3:0] y, input logic c);
        logic [3:0] yy;
        logic [4:0] r;
        yy = sb ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {4'b0, c ^ sb};
        return {28'b0, r};
    endfunction

    function automatic logic [32:0] model8(input logic sb, input logic [7:0] x,
                                           input logic [7:0] y, input logic c);
        logic [7:0] yy;
        logic [8:0] r;
        logic       ov;
        yy = sb ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {8'b0, c ^ sb};
        ov = (x[7] == yy[7]) && (r[7] != x[7]);
        return {23'b0, ov, r};
    endfunction

    function automatic logic [32:0] model32(input logic sb, input logic [31:0] x,
                                            input logic [31:0] y, input logic c);
        logic [31:0] yy;
        yy = sb ? ~y : y;
        return {1'b0, x} + {1'b0, yy} + {32'b0, c ^ sb};
    endfunction

    task automatic cmp(input string nm, input logic [35:0] act, input logic [35:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @ecnt=%0d: got %h expected %h", nm, ecnt, act, exp);
        end
    endtask

    // One clock: record any accepted operation, then check all outputs 1 ns after the edge.
    task automatic step();
        exp2_t e2;
        exp4_t e4x;
        if (in_valid && ce && !rst) begin
            e2.e4  = model4(sub, a[3:0], b[3:0], cin);
            e2.e8  = model8(sub, a[7:0], b[7:0], cin);
            if (use_tab) e2.e8[9] = tab_ovf;
            e2.due = ecnt + 2;
            e4x.e32 = use_tab ? tab_res : model32(sub, a, b, cin);
            e4x.due = ecnt + 4;
            q2.push_back(e2);
            q4.push_back(e4x);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            q2.delete();
            q4.delete();
            cmp("rst_u4", act4, 36'd0);
            cmp("rst_u32", act32, 36'd0);
`ifdef PIPE_ADDSUB_OVF_EN
            cmp("rst_u8", act8, 36'd0);
`endif
        end else if (!ce) begin
            cmp("stall_u4", act4, prev4);
            cmp("stall_u32", act32, prev32);
`ifdef PIPE_ADDSUB_OVF_EN
            cmp("stall_u8", act8, prev8);
`endif
        end else begin
            ecnt++;
            if (q2.size() > 0 && q2[0].due == ecnt) begin
                e2 = q2.pop_front();
                cmp("res_u4", act4, {30'b0, 1'b1, e2.e4[4:0]});
`ifdef PIPE_ADDSUB_OVF_EN
                cmp("res_u8", act8, {25'b0, 1'b1, e2.e8[9:0]});
`endif
            end else begin
                cmp("idle_u4", {35'b0, ov4}, 36'd0);
`ifdef PIPE_ADDSUB_OVF_EN
                cmp("idle_u8", {35'b0, ov8}, 36'd0);
`endif
            end
            if (q4.size() > 0 && q4[0].due == ecnt) begin
                e4x = q4.pop_front();
                cmp("res_u32", act32, {2'b0, 1'b1, e4x.e32});
            end else begin
                cmp("idle_u32", {35'b0, ov32}, 36'd0);
            end
        end
        prev4  = act4;
        prev32 = act32;
`ifdef PIPE_ADDSUB_OVF_EN
        prev8  = act8;
`endif
    endtask

    task automatic op(input logic sb, input logic [31:0] x, input logic [31:0] y, input logic c);
        in_valid = 1'b1;
        sub      = sb;
        a        = x;
        b        = y;
        cin      = c;
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        use_tab = 1'b0; tab_res = '0; tab_ovf = 1'b0;

        tab[0]  = '{1'b1, 32'd0,         32'd1,         1'b0, 33'h0_FFFF_FFFF, 1'b0};
        tab[1]  = '{1'b1, 32'd5,         32'd5,         1'b0, 33'h1_0000_0000, 1'b0};
        tab[2]  = '{1'b0, 32'hFFFF_FFFF, 32'd0,         1'b1, 33'h1_0000_0000, 1'b0};
        tab[3]  = '{1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789, 1'b1};
        tab[4]  = '{1'b1, 32'd10,        32'd3,         1'b1, 33'h1_0000_0006, 1'b0};
        tab[5]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000, 1'b0};
        tab[6]  = '{1'b1, 32'd0,         32'd0,         1'b1, 33'h0_FFFF_FFFF, 1'b0};
        tab[7]  = '{1'b0, 32'h0000_FFFF, 32'd1,         1'b0, 33'h0_0001_0000, 1'b0};
        tab[8]  = '{1'b0, 32'h7F,        32'h01,        1'b0, 33'h0_0000_0080, 1'b1};
        tab[9]  = '{1'b1, 32'h80,        32'h01,        1'b0, 33'h1_0000_007F, 1'b1};
        tab[10] = '{1'b0, 32'h01,        32'h01,        1'b0, 33'h0_0000_0002, 1'b0};

        step();
        step();
        rst = 1'b0;

        // Exhaustive 4-bit add, back-to-back from the first cycle after reset
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++)
                    op(1'b0, 32'(x), 32'(y), c[0]);
        idle(5);

        for (int i = 0; i < 11; i++) begin
            use_tab = 1'b1;
            tab_res = tab[i].res;
            tab_ovf = tab[i].ovf;
            op(tab[i].sb, tab[i].x, tab[i].y, tab[i].c);
            use_tab = 1'b0;
        end
        idle(5);

        // Alternating add/sub with random operands
        for (int i = 0; i < 40; i++)
            op(i[0], $urandom, $urandom, 1'($urandom_range(0, 1)));
        idle(5);

        // Three-cycle stall mid-stream; inputs offered during the stall must be ignored
        for (int i = 0; i < 4; i++)
            op(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            step();
        end
        ce = 1'b1;
        for (int i = 0; i < 4; i++)
            op(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
        idle(6);

        // Reset with three operations in flight: none of them may emerge
        for (int i = 0; i < 3; i++)
            op(1'b0, $urandom, $urandom, 1'b1);
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        idle(8);

        cmp("drain_q2", 36'(q2.size()), 36'd0);
        cmp("drain_q4", 36'(q4.size()), 36'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
